// File: rtl/rr_burst_fifo_scheduler.sv
// Round-robin pop scheduler for a bank of FWFT FIFOs feeding one shared mux channel.
// Holds an owner for up to MAX_BURST consecutive pops, then rotates to the next non-empty FIFO.
module rr_burst_fifo_scheduler #(
   parameter int unsigned NUM_FIFOS = 4,
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned TAGWIDTH  = $clog2(NUM_FIFOS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [NUM_FIFOS-1:0] empty,
   input  logic                 out_rdy,
   output logic [NUM_FIFOS-1:0] gnt,
   output logic [TAGWIDTH-1:0]  gnt_sel,
   output logic                 gnt_vld,
   output logic [TAGWIDTH-1:0]  owner,
   output logic                 locked
);

   localparam int unsigned CNTW = $clog2(MAX_BURST + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t              state;
   logic [TAGWIDTH-1:0] rr_ptr;
   logic [CNTW-1:0]     burst_cnt;

   logic                lock_ok;
   logic                any_req;
   logic                fire;
   logic                burst_done;
   logic [TAGWIDTH-1:0] scan_idx;
   logic [TAGWIDTH-1:0] cur;
   logic [TAGWIDTH-1:0] probe;
   logic [CNTW-1:0]     burst_cnt_eff;

   function automatic logic [TAGWIDTH-1:0] inc_wrap(input logic [TAGWIDTH-1:0] v);
      return (32'(v) == NUM_FIFOS - 1) ? '0 : v + 1'b1;
   endfunction

   // First non-empty FIFO at or after rr_ptr, modulo NUM_FIFOS.
   always_comb begin
      scan_idx = '0;
      probe    = rr_ptr;
      for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
         if (!empty[probe]) begin
            scan_idx = probe;
            break;
         end
         probe = inc_wrap(probe);
      end
   end

   assign lock_ok       = (state == BURST) && !empty[owner];
   assign any_req       = |(~empty);
   assign cur           = lock_ok ? owner : scan_idx;
   assign fire          = rst_n && en && out_rdy && any_req;
   assign burst_cnt_eff = lock_ok ? burst_cnt : '0;
   assign burst_done    = (32'(burst_cnt_eff) + 32'd1) == MAX_BURST;

   // Zero-latency pop strobe so FWFT data is consumed in the same cycle it is selected.
   always_comb begin
      gnt     = '0;
      gnt_sel = '0;
      if (fire) begin
         gnt[cur] = 1'b1;
         gnt_sel  = cur;
      end
   end

   assign gnt_vld = fire;
   assign locked  = (state == BURST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         owner     <= '0;
         burst_cnt <= '0;
      end else if (en) begin
         if (fire && burst_done) begin
            state     <= IDLE;
            burst_cnt <= '0;
            rr_ptr    <= inc_wrap(cur);
         end else if (fire) begin
            state     <= BURST;
            owner     <= cur;
            burst_cnt <= burst_cnt_eff + 1'b1;
         end else if ((state == BURST) && empty[owner]) begin
            // Owner drained while stalled or idle: release the lock and resume after it.
            state     <= IDLE;
            burst_cnt <= '0;
            rr_ptr    <= inc_wrap(owner);
         end
      end
   end

`ifndef SYNTHESIS
   a_onehot_gnt : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
   a_no_empty_pop : assert property (@(posedge clk) disable iff (!rst_n) (gnt & empty) == '0);
   a_vld_matches : assert property (@(posedge clk) disable iff (!rst_n) gnt_vld == (|gnt));
`endif

endmodule

// File: tb/tb_rr_burst_fifo_scheduler.sv
// Scoreboard bench for rr_burst_fifo_scheduler: stimulus pushes per-cycle expectations,
// negedge monitors pop and compare, one monitor per DUT instance (MAX_BURST=4 and MAX_BURST=1).
module tb_rr_burst_fifo_scheduler;

   typedef struct {
      logic [3:0] gnt;
      logic [1:0] owner;
      logic       locked;
      string      name;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       en_a = 1'b0, rdy_a = 1'b0;
   logic [3:0] empty_a = 4'b1111;
   logic [3:0] gnt_a;
   logic [1:0] sel_a, owner_a;
   logic       vld_a, locked_a;

   logic       en_b = 1'b0, rdy_b = 1'b0;
   logic [3:0] empty_b = 4'b1111;
   logic [3:0] gnt_b;
   logic [1:0] sel_b, owner_b;
   logic       vld_b, locked_b;

   exp_t q_a[$];
   exp_t q_b[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   rr_burst_fifo_scheduler #(.NUM_FIFOS(4), .MAX_BURST(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en_a), .empty(empty_a), .out_rdy(rdy_a),
      .gnt(gnt_a), .gnt_sel(sel_a), .gnt_vld(vld_a), .owner(owner_a), .locked(locked_a));

   rr_burst_fifo_scheduler #(.NUM_FIFOS(4), .MAX_BURST(1)) u_rr1 (
      .clk(clk), .rst_n(rst_n), .en(en_b), .empty(empty_b), .out_rdy(rdy_b),
      .gnt(gnt_b), .gnt_sel(sel_b), .gnt_vld(vld_b), .owner(owner_b), .locked(locked_b));

   function automatic logic [1:0] enc(input logic [3:0] g);
      logic [1:0] r = 2'd0;
      for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
      return r;
   endfunction

   task automatic chk(input string name, input string field, input logic [3:0] act,
                      input logic [3:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s %s: got %b expected %b", name, field, act, req);
      end
   endtask

   task automatic compare(input exp_t e, input logic [3:0] g, input logic [1:0] s,
                          input logic v, input logic [1:0] o, input logic l);
      chk(e.name, "gnt", g, e.gnt);
      chk(e.name, "gnt_sel", 4'(s), 4'(enc(e.gnt)));
      chk(e.name, "gnt_vld", 4'(v), 4'(|e.gnt));
      chk(e.name, "owner", 4'(o), 4'(e.owner));
      chk(e.name, "locked", 4'(l), 4'(e.locked));
   endtask

   always @(negedge clk) begin
      if (q_a.size() > 0) compare(q_a.pop_front(), gnt_a, sel_a, vld_a, owner_a, locked_a);
      if (q_b.size() > 0) compare(q_b.pop_front(), gnt_b, sel_b, vld_b, owner_b, locked_b);
   end

   // One cycle on instance A: drive after the edge, expectation checked at the next negedge.
   task automatic step_a(input string nm, input logic e, input logic [3:0] emp, input logic r,
                         input logic [3:0] g, input logic [1:0] o, input logic l);
      exp_t x;
      @(posedge clk);
      #1;
      en_a = e; empty_a = emp; rdy_a = r;
      x.gnt = g; x.owner = o; x.locked = l; x.name = nm;
      q_a.push_back(x);
   endtask

   task automatic step_b(input string nm, input logic [3:0] emp, input logic [3:0] g);
      exp_t x;
      @(posedge clk);
      #1;
      en_b = 1'b1; empty_b = emp; rdy_b = 1'b1;
      x.gnt = g; x.owner = 2'd0; x.locked = 1'b0; x.name = nm;
      q_b.push_back(x);
   endtask

   initial begin
      logic [3:0] g;
      logic [1:0] o;
      int         f;

      // Reset held with every FIFO requesting: no grant may escape.
      step_a("reset", 1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
      step_a("reset2", 1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);

      // Release and run full-load bursts: 4x0001, 4x0010, 4x0100, 4x1000, 4x0001.
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      q_a.push_back('{gnt: 4'b0001, owner: 2'd0, locked: 1'b0, name: "first_after_reset"});
      for (int k = 1; k < 20; k++) begin
         f = (k / 4) % 4;
         g = 4'(1) << f;
         o = ((k % 4) == 0) ? 2'((f + 3) % 4) : 2'(f);
         step_a("full_load", 1'b1, 4'b0000, 1'b1, g, o, (k % 4) != 0);
      end

      // Bring owner=2 to burst_cnt=2, stall 3 cycles, then finish burst and rotate to 3.
      step_a("to_fifo1", 1'b1, 4'b0000, 1'b1, 4'b0010, 2'd0, 1'b0);
      for (int k = 0; k < 3; k++) step_a("to_fifo1", 1'b1, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1);
      step_a("fifo2_pop1", 1'b1, 4'b0000, 1'b1, 4'b0100, 2'd1, 1'b0);
      step_a("fifo2_pop2", 1'b1, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1);
      for (int k = 0; k < 3; k++) step_a("stall", 1'b1, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b1);
      step_a("fifo2_pop3", 1'b1, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1);
      step_a("fifo2_pop4", 1'b1, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1);
      step_a("rotate_3", 1'b1, 4'b0000, 1'b1, 4'b1000, 2'd2, 1'b0);

      // en=0 freezes grants and state.
      step_a("en_off", 1'b0, 4'b0000, 1'b1, 4'b0000, 2'd3, 1'b1);
      step_a("en_off2", 1'b0, 4'b0000, 1'b1, 4'b0000, 2'd3, 1'b1);
      step_a("en_on", 1'b1, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b1);

      // Asynchronous reset mid-burst: outputs and state clear immediately.
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      q_a.push_back('{gnt: 4'b0000, owner: 2'd0, locked: 1'b0, name: "reset_mid_burst"});
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      en_a = 1'b1; empty_a = 4'b1101; rdy_a = 1'b1;
      q_a.push_back('{gnt: 4'b0010, owner: 2'd0, locked: 1'b0, name: "sole_fifo1"});

      // FIFO1 drains after 2 pops, FIFO3 takes over with no idle cycle.
      step_a("sole_fifo1_b", 1'b1, 4'b1101, 1'b1, 4'b0010, 2'd1, 1'b1);
      step_a("handoff_3", 1'b1, 4'b0111, 1'b1, 4'b1000, 2'd1, 1'b1);
      step_a("all_empty", 1'b1, 4'b1111, 1'b1, 4'b0000, 2'd3, 1'b1);
      step_a("unlocked", 1'b1, 4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0);
      step_a("park", 1'b0, 4'b1111, 1'b0, 4'b0000, 2'd3, 1'b0);

      // MAX_BURST=1 with FIFOs 1 and 3 non-empty: strict alternation.
      for (int k = 0; k < 8; k++)
         step_b("rr1_alt", 4'b0101, (k % 2 == 0) ? 4'b0010 : 4'b1000);

      repeat (3) @(posedge clk);
      if (q_a.size() != 0 || q_b.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL drain: %0d/%0d expectations left unchecked", q_a.size(), q_b.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
